sum_accumulator: RTL and testbench
==================================

// Module: sum_accumulator
// PURPOSE
//  Downstream stage of half_adder: consumes its 10-bit sum stream (data_out/out_valid) and
//  accumulates blocks of BLOCK_LEN valid sums into one wide total.
//  Presents each total through a registered valid/ready output slot.
//  The upstream stage has no backpressure, so accumulation never stalls; overruns are flagged.
// PARAMETERS
//  IN_W       10  width of incoming sum (half_adder data_out width)
//  ACC_W      16  accumulator / result width; ACC_W > IN_W
//  BLOCK_LEN  4   valid samples per block; >= 2
// PORTS
//  clk        in   1                    single clock, all logic on posedge
//  rst        in   1                    synchronous, active-high reset
//  sum_in     in   IN_W                 sample; connects to half_adder data_out
//  sum_valid  in   1                    sample qualifier; connects to half_adder out_valid
//  flush      in   1                    close current partial block early
//  acc_out    out  ACC_W                block total, stable while acc_valid=1
//  acc_count  out  $clog2(BLOCK_LEN+1)  samples contained in acc_out
//  acc_sat    out  1                    block total saturated (see CONFIGURATION)
//  acc_valid  out  1                    output slot full
//  acc_ready  in   1                    consumer accepts slot when acc_valid & acc_ready
//  overrun    out  1                    sticky: a completed block was discarded
// BEHAVIOUR
//  - Reset: all outputs 0; running sum=0, count=0, sat=0; slot empty. Reset mid-block discards partial sum.
//  - Running stage (never stalls):
//      - sum_valid=1: sum += zero-extended sum_in; count += 1.
//      - Block closes when count reaches BLOCK_LEN, or when flush=1 with count>0 after the current cycle's sample.
//      - flush with count=0 and no sample: no effect.
//      - flush with sum_valid in the same cycle: sample is included in the closing block.
//      - On close, the running stage restarts at sum=0, count=0. A sample on the closing cycle belongs to the closing block.
//  - Output slot:
//      - Latency: block closes at cycle N; acc_valid=1 at N+1.
//      - acc_out, acc_count and acc_sat hold until the handshake.
//      - acc_valid & acc_ready: slot empties next cycle unless a new block closes in the same cycle. If one does, the slot reloads and acc_valid stays 1 (back-to-back, no bubble).
//      - Block closes while slot full and acc_ready=0: new block is discarded, overrun<=1, and the slot is unchanged.
//      - overrun clears only on rst.
//  - Arithmetic: unsigned; max block sum BLOCK_LEN*(2^IN_W-1).
//  - acc_ready is ignored while acc_valid=0.
// CONFIGURATION
//  SUM_ACC_SAT_EN defined:
//    - The add clamps at 2^ACC_W-1.
//    - A sticky per-block sat bit sets on clamp and is copied to acc_sat on close.
//  SUM_ACC_SAT_EN undefined:
//    - The add wraps modulo 2^ACC_W.
//    - acc_sat tied 0.
// TESTING
//  (defaults, acc_ready=1 unless stated)
//  1. Sums 71,61,56,15 on 4 consecutive cycles -> one cycle after 4th: acc_valid=1, acc_out=203, acc_count=4.
//  2. Sums 10,20, then flush alone -> acc_out=30, acc_count=2. Flush with count=0 -> acc_valid stays 0.
//  3. sum_valid gapped (1,0,1,0,1,0,1) with 100 each -> acc_out=400 one cycle after last sample; gaps are not counted.
//  4. acc_ready=0; close block A=40 (4x10), then block B=80 (4x20) -> acc_out stays 40, overrun=1.
//     Then acc_ready=1 -> A accepted, acc_valid=0 next cycle.
//  5. ACC_W=11, BLOCK_LEN=4, four sums of 1023 (total 4092 > 2047):
//     - with SUM_ACC_SAT_EN: acc_out=2047, acc_sat=1.
//     - without SUM_ACC_SAT_EN: acc_out=4092 mod 2048=2044, acc_sat=0.
//  6. rst after 2 of 4 samples (5,5), then 1,2,3,4 -> acc_out=10, no stale sum; overrun=0.

Source files
------------

// File: rtl/sum_acc_if.sv
// Sum-stream in / block-total out bundle between half_adder, sum_accumulator and its consumer.
// slave = accumulator side; master = the upstream sample source plus the downstream consumer.
interface sum_acc_if #(
  parameter int IN_W      = 10,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  logic [IN_W-1:0]  sum_in;
  logic             sum_valid;
  logic             flush;
  logic [ACC_W-1:0] acc_out;
  logic [CNT_W-1:0] acc_count;
  logic             acc_sat;
  logic             acc_valid;
  logic             acc_ready;
  logic             overrun;

  modport master (
    output sum_in, sum_valid, flush, acc_ready,
    input  acc_out, acc_count, acc_sat, acc_valid, overrun
  );

  modport slave (
    input  sum_in, sum_valid, flush, acc_ready,
    output acc_out, acc_count, acc_sat, acc_valid, overrun
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates BLOCK_LEN valid sums (or a flushed partial block) into one total; SUM_ACC_SAT_EN selects clamp vs wrap.
// Total valid one cycle after close; input never stalls, a close into a full unaccepted slot is dropped and flags overrun.
module sum_accumulator #(
  parameter int IN_W      = 10,
  parameter int ACC_W     = 16,
  parameter int BLOCK_LEN = 4
) (
  input  logic     clk,
  input  logic     rst,
  sum_acc_if.slave bus
);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);

  typedef struct packed {
    logic [ACC_W-1:0] total;
    logic [CNT_W-1:0] count;
    logic             sat;
  } res_t;

  logic [ACC_W-1:0] sum_q, sum_d, sum_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic             sat_q, sat_d, sat_nxt;
  logic             close;

  res_t             slot_q, slot_d;
  logic             slot_vld_q, slot_vld_d;
  logic             overrun_q, overrun_d;

`ifdef SUM_ACC_SAT_EN
  logic [ACC_W:0]   add_w;
`else
  logic [ACC_W-1:0] add_w;
`endif

  // Running stage: sum/count after this cycle's sample, then decide whether the block closes.
  always_comb begin
    sum_nxt = sum_q;
    cnt_nxt = cnt_q;
    sat_nxt = sat_q;
`ifdef SUM_ACC_SAT_EN
    add_w = {1'b0, sum_q} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.sum_in};
`else
    add_w = sum_q + {{(ACC_W - IN_W){1'b0}}, bus.sum_in};
`endif
    if (bus.sum_valid) begin
      cnt_nxt = cnt_q + CNT_W'(1);
`ifdef SUM_ACC_SAT_EN
      if (add_w[ACC_W]) begin
        sum_nxt = '1;
        sat_nxt = 1'b1;
      end else begin
        sum_nxt = add_w[ACC_W-1:0];
      end
`else
      sum_nxt = add_w;
`endif
    end

    close = (cnt_nxt == CNT_W'(BLOCK_LEN)) || (bus.flush && (cnt_nxt != '0));

    sum_d = close ? '0   : sum_nxt;
    cnt_d = close ? '0   : cnt_nxt;
    sat_d = close ? 1'b0 : sat_nxt;
  end

  // Output slot: a close may reload in the same cycle the old total is accepted.
  always_comb begin
    slot_d     = slot_q;
    slot_vld_d = slot_vld_q;
    overrun_d  = overrun_q;
    if (close) begin
      if (!slot_vld_q || bus.acc_ready) begin
        slot_d.total = sum_nxt;
        slot_d.count = cnt_nxt;
        slot_d.sat   = sat_nxt;
        slot_vld_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (slot_vld_q && bus.acc_ready) begin
      slot_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      slot_q     <= '0;
      slot_vld_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      slot_q     <= slot_d;
      slot_vld_q <= slot_vld_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.acc_out   = slot_q.total;
  assign bus.acc_count = slot_q.count;
  assign bus.acc_sat   = slot_q.sat;
  assign bus.acc_valid = slot_vld_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: default 16-bit instance plus an 11-bit instance for the overflow case.
// Honours SUM_ACC_SAT_EN when choosing the expected overflow result.
module tb_sum_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sum_acc_if #(.IN_W(10), .ACC_W(16), .BLOCK_LEN(4)) bus0 ();
  sum_acc_if #(.IN_W(10), .ACC_W(11), .BLOCK_LEN(4)) bus1 ();

  sum_accumulator #(.IN_W(10), .ACC_W(16), .BLOCK_LEN(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  sum_accumulator #(.IN_W(10), .ACC_W(11), .BLOCK_LEN(4)) u_narrow (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  typedef struct {
    int total;
    int count;
    int sat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state for the default instance
  int   m_sum = 0;
  int   m_cnt = 0;
  bit   m_full = 1'b0;
  bit   m_ovr = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One cycle on the default instance: update model, drive, clock, check flags.
  task automatic step(input bit v, input logic [9:0] d, input bit f, input bit rdy);
    bit accept;
    bit close;
    bus0.sum_valid = v;
    bus0.sum_in    = d;
    bus0.flush     = f;
    bus0.acc_ready = rdy;
    accept = m_full && rdy;
    if (v) begin
      m_sum = (m_sum + int'(d)) % 65536;
      m_cnt++;
    end
    close = (m_cnt == 4) || (f && m_cnt > 0);
    if (close) begin
      if (!m_full || rdy) begin
        sb.push_back('{m_sum, m_cnt, 0});
        m_full = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      m_sum = 0;
      m_cnt = 0;
    end else if (accept) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("acc_valid", int'(bus0.acc_valid), int'(m_full));
    chk("overrun", int'(bus0.overrun), int'(m_ovr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus0.sum_valid = 1'b0;
    bus0.sum_in    = '0;
    bus0.flush     = 1'b0;
    bus0.acc_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_sum = 0;
    m_cnt = 0;
    m_full = 1'b0;
    m_ovr = 1'b0;
    sb.delete();
    chk("rst_acc_valid", int'(bus0.acc_valid), 0);
    chk("rst_acc_out", int'(bus0.acc_out), 0);
    chk("rst_acc_count", int'(bus0.acc_count), 0);
    chk("rst_acc_sat", int'(bus0.acc_sat), 0);
    chk("rst_overrun", int'(bus0.overrun), 0);
  endtask

  // Handshake completes on the coming posedge; compare the slot against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus0.acc_valid && bus0.acc_ready) begin
      if (sb.size() == 0) begin
        chk("sb_pop", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_acc_out", int'(bus0.acc_out), e.total);
        chk("sb_acc_count", int'(bus0.acc_count), e.count);
        chk("sb_acc_sat", int'(bus0.acc_sat), e.sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_out;
    int exp_sat;
    int s1[4];
    int s6[4];
    s1 = '{71, 61, 56, 15};
    s6 = '{1, 2, 3, 4};

    bus1.sum_valid = 1'b0;
    bus1.sum_in    = '0;
    bus1.flush     = 1'b0;
    bus1.acc_ready = 1'b1;
    @(posedge clk);
    do_reset();

    // 1. full block of four consecutive sums
    for (int i = 0; i < 4; i++) step(1'b1, 10'(s1[i]), 1'b0, 1'b1);
    chk("t1_acc_out", int'(bus0.acc_out), 203);
    chk("t1_acc_count", int'(bus0.acc_count), 4);
    step(1'b0, 10'd0, 1'b0, 1'b1);

    // 2. partial block closed by a lone flush, then an empty flush
    step(1'b1, 10'd10, 1'b0, 1'b1);
    step(1'b1, 10'd20, 1'b0, 1'b1);
    step(1'b0, 10'd0, 1'b1, 1'b1);
    chk("t2_acc_out", int'(bus0.acc_out), 30);
    chk("t2_acc_count", int'(bus0.acc_count), 2);
    step(1'b0, 10'd0, 1'b1, 1'b1);
    step(1'b0, 10'd0, 1'b1, 1'b1);

    // 3. gapped sum_valid
    for (int i = 0; i < 7; i++) step(i % 2 == 0, 10'd100, 1'b0, 1'b1);
    chk("t3_acc_out", int'(bus0.acc_out), 400);
    step(1'b0, 10'd0, 1'b0, 1'b1);

    // flush together with a sample, one-sample blocks back-to-back with no bubble
    for (int i = 0; i < 3; i++) step(1'b1, 10'(7 + i), 1'b1, 1'b1);
    step(1'b0, 10'd0, 1'b0, 1'b1);

    // 4. overrun while the consumer stalls
    for (int i = 0; i < 4; i++) step(1'b1, 10'd10, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 10'd20, 1'b0, 1'b0);
    chk("t4_acc_out_held", int'(bus0.acc_out), 40);
    step(1'b0, 10'd0, 1'b0, 1'b1);
    step(1'b0, 10'd0, 1'b0, 1'b1);

    // 6. reset mid-block discards the partial sum and clears overrun
    step(1'b1, 10'd5, 1'b0, 1'b1);
    step(1'b1, 10'd5, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 10'(s6[i]), 1'b0, 1'b1);
    chk("t6_acc_out", int'(bus0.acc_out), 10);
    chk("t6_acc_count", int'(bus0.acc_count), 4);
    step(1'b0, 10'd0, 1'b0, 1'b1);

    // 5. overflow on the 11-bit instance
`ifdef SUM_ACC_SAT_EN
    exp_out = 2047;
    exp_sat = 1;
`else
    exp_out = 2044;
    exp_sat = 0;
`endif
    for (int i = 0; i < 4; i++) begin
      bus1.sum_valid = 1'b1;
      bus1.sum_in    = 10'd1023;
      @(posedge clk);
      #1;
    end
    bus1.sum_valid = 1'b0;
    chk("t5_acc_valid", int'(bus1.acc_valid), 1);
    chk("t5_acc_out", int'(bus1.acc_out), exp_out);
    chk("t5_acc_sat", int'(bus1.acc_sat), exp_sat);
    chk("t5_acc_count", int'(bus1.acc_count), 4);
    @(posedge clk);
    #1;
    chk("t5_drained", int'(bus1.acc_valid), 0);

    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
